// File: rtl/load_store_unit_if.sv
// Valid/ready data-memory bus: the LSU is master, memory is slave.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit with stall, timeout and lane steering.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [2:0]         func3,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        MEM_w_data,
  output logic               lsu_stall,
  output logic [31:0]        load_data,
  output logic               load_valid,
  output logic               lsu_error,
  load_store_unit_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic        r_err, r_is_load, r_we;
  logic [2:0]  r_func3;
  logic [1:0]  r_off;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;

  logic        w_access, w_legal, w_bad, w_timeout;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_access  = MemRead | MemWrite;
  assign w_legal   = (func3[1:0] != 2'b11) & ~(func3[2] & (MemWrite | func3[1]));
  assign w_timeout = (r_cnt == LP_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((func3[1:0] == 2'b01) & ALU_result[0]) |
                      ((func3[1:0] == 2'b10) & (|ALU_result[1:0]));
  assign w_bad      = ~w_legal | w_misalign;
`else
  assign w_bad      = ~w_legal;
`endif

  // Lane offset ignores the low bits a halfword/word cannot use.
  always_comb begin
    w_off   = ALU_result[1:0];
    w_be    = 4'b1111;
    w_wdata = MEM_w_data;
    case (func3[1:0])
      2'b00: begin
        if (MemWrite) begin
          w_be    = 4'b0001 << ALU_result[1:0];
          w_wdata = {4{MEM_w_data[7:0]}};
        end
      end
      2'b01: begin
        w_off = {ALU_result[1], 1'b0};
        if (MemWrite) begin
          w_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{MEM_w_data[15:0]}};
        end
      end
      default: w_off = 2'b00;
    endcase
  end

  always_comb begin
    w_byte = bus.bus_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (r_func3[1:0])
      2'b00:   w_ext = {{24{w_byte[7] & ~r_func3[2]}}, w_byte};
      2'b01:   w_ext = {{16{w_half[15] & ~r_func3[2]}}, w_half};
      default: w_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_next = w_bad ? S_DONE : S_REQ;
      S_REQ:   if (bus.bus_ready || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall is gated by reset so the core is released the instant rst asserts.
  always_comb begin
    lsu_stall   = rst & (((r_state == S_IDLE) & w_access) | (r_state == S_REQ));
    load_valid  = (r_state == S_DONE) & r_is_load & ~r_err;
    lsu_error   = (r_state == S_DONE) & r_err;
    bus.bus_req = (r_state == S_REQ);
  end

  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_be    = r_be;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_is_load <= 1'b0;
      r_we      <= 1'b0;
      r_func3   <= '0;
      r_off     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      load_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_access) begin
            r_err     <= w_bad;
            r_is_load <= ~MemWrite;
            if (w_bad) begin
              load_data <= '0;
            end else begin
              r_we    <= MemWrite;
              r_func3 <= func3;
              r_off   <= w_off;
              r_addr  <= {ALU_result[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
            end
          end
        end
        S_REQ: begin
          if (bus.bus_ready) begin
            r_cnt <= '0;
            if (r_is_load) load_data <= w_ext;
          end else if (w_timeout) begin
            r_cnt     <= '0;
            r_err     <= 1'b1;
            load_data <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_err <= 1'b0;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the RV32I single-cycle datapath. It consumes the datapath's effective address (`ALU_result`), store data (`MEM_w_data`) and `func3`, and drives a valid/ready data-memory bus. It returns sign- or zero-extended load data to the writeback mux. While a transaction is outstanding it stalls the core by holding the PC and instruction.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16 — cycles in REQ without `bus_ready` before abort; legal range 1..255.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `MemRead`  in  1  — current instruction is a load.
- `MemWrite`  in  1  — current instruction is a store; wins if both are high.
- `func3`  in  3  — `instruction_code[14:12]`.
- `ALU_result`  in  32  — effective byte address.
- `MEM_w_data`  in  32  — store data (rs2).
- `lsu_stall`  out  1  — core must hold PC/instruction and suppress RegWrite.
- `load_data`  out  32  — extended load result, registered.
- `load_valid`  out  1  — one-cycle pulse; `load_data` is valid for writeback.
- `lsu_error`  out  1  — one-cycle pulse on illegal func3, misalignment or timeout.
- `bus_req`, `bus_we`  out  1 each — request and write strobe.
- `bus_addr`  out  32  — word-aligned (`[1:0]=0`).
- `bus_wdata`  out  32, `bus_be`  out  4 — lane-aligned data and byte enables.
- `bus_ready`  in  1, `bus_rdata`  in  32 — completion and read word.

## Operation
- FSM has three states: IDLE, REQ, DONE.
- **IDLE**
  - If `MemRead|MemWrite` with legal, aligned access: register bus signals and go to REQ.
  - If the access is illegal or misaligned: go to DONE with an error flag set; no bus transaction.
  - Otherwise stay in IDLE.
- **REQ**
  - `bus_req=1`, and bus outputs are held stable.
  - On `bus_ready`: capture and extend `bus_rdata` (loads only), then go to DONE.
  - Timeout counter increments each cycle without ready. When it reaches `TIMEOUT_CYCLES`, go to DONE with error and `load_data=0`.
- **DONE**
  - `load_valid=1` for loads without error; `lsu_error=1` if the error flag is set.
  - Always returns to IDLE; never accepts a new request.
- `lsu_stall` is combinational: `(IDLE & (MemRead|MemWrite)) | REQ`. It is 0 in DONE so the core writes back and advances.
- Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Byte lane is selected by `addr[1:0]`; halfword lane by `addr[1]`.
  - Sign extension for LB/LH, zero extension for LBU/LHU.
- Stores: SB 000, SH 001, SW 010.
  - SB: `bus_be = 4'b0001 << addr[1:0]`, byte replicated ×4.
  - SH: `bus_be = 0011` or `1100`, halfword replicated ×2.
  - SW: `bus_be = 1111`.
  - Loads drive `bus_be = 1111`, `bus_we = 0`.
- Any other func3 is illegal.
- Misaligned: halfword with `addr[0]=1`; word with `addr[1:0]≠0`.

## Timing
- Reset values: state IDLE, all outputs 0, `load_data=0`, timeout counter 0. Reset takes effect immediately, including mid-REQ: `bus_req` drops asynchronously.
- Best-case access, request visible in cycle 0:
  - Cycle 1: `bus_req`, with `bus_ready` high.
  - Cycle 2: DONE, `load_valid`, `lsu_stall=0`.
  - Core advances at the end of cycle 2, so a memory instruction takes 3 cycles minimum.
- Each wait cycle in REQ adds one cycle.
- Error path: IDLE → DONE, so the instruction takes 2 cycles.
- Timeout: DONE is entered `TIMEOUT_CYCLES+1` cycles after REQ entry, with `lsu_error` high.
- A `bus_ready` arriving in the same cycle the counter hits its limit counts as success, not timeout.
- `bus_rdata` is sampled only in REQ with `bus_ready=1`; `bus_ready` outside REQ is ignored.
- Back-to-back memory instructions: the next one is seen in the IDLE following DONE; there is no bubble beyond DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses are flagged as errors and suppressed (no bus cycle).
- Not defined:
  - Low address bits are ignored for alignment purposes: halfword uses `addr[1]`, word forces `[1:0]=0`.
  - The access proceeds normally.
  - `lsu_error` is raised only for illegal func3 or timeout.

## Test plan
- LW from 0x100, `bus_ready` immediate, `rdata=0xDEADBEEF` → `bus_be=1111`, stall 2 cycles, `load_valid` with `load_data=0xDEADBEEF` in cycle 2.
- LB/LBU from 0x103 with `rdata=0x80FF_1234` → LB gives `0xFFFFFF80`, LBU gives `0x00000080`; LH from 0x102 gives `0xFFFF80FF`.
- SB to 0x101 with `MEM_w_data=0x000000AB`, `bus_ready` after 3 wait cycles → `bus_be=0010`, `bus_wdata=0xABABABAB`, `bus_we=1`, stall 5 cycles, no `load_valid`.
- `bus_ready` never asserted, `TIMEOUT_CYCLES=4` → `lsu_error` pulse 5 cycles after REQ entry, `load_data=0`, FSM returns to IDLE.
- LW at 0x102 → with `LSU_MISALIGN_TRAP_EN`: `lsu_error`, no `bus_req`; without: `bus_addr=0x100`, normal load. func3=011 → `lsu_error` in both builds.
- `rst` low while in REQ → `bus_req` and `lsu_stall` drop immediately; after release, a fresh LW completes normally.
